// File: rtl/p2s_serializer.sv
// p2s_serializer: 16-element parallel frame to valid/ready serial stream.
// Ports: clk, rst (async, active-high); p_valid/p_ready/drop and y0..y15 on
// the frame side; s_valid/s_ready/s_d/s_idx/s_last on the serial side.
module p2s_serializer #(
  parameter int unsigned DATA_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     p_valid,
  input  logic signed [DATA_W-1:0] y0,
  input  logic signed [DATA_W-1:0] y1,
  input  logic signed [DATA_W-1:0] y2,
  input  logic signed [DATA_W-1:0] y3,
  input  logic signed [DATA_W-1:0] y4,
  input  logic signed [DATA_W-1:0] y5,
  input  logic signed [DATA_W-1:0] y6,
  input  logic signed [DATA_W-1:0] y7,
  input  logic signed [DATA_W-1:0] y8,
  input  logic signed [DATA_W-1:0] y9,
  input  logic signed [DATA_W-1:0] y10,
  input  logic signed [DATA_W-1:0] y11,
  input  logic signed [DATA_W-1:0] y12,
  input  logic signed [DATA_W-1:0] y13,
  input  logic signed [DATA_W-1:0] y14,
  input  logic signed [DATA_W-1:0] y15,
  output logic                     p_ready,
  output logic                     drop,
  output logic                     s_valid,
  input  logic                     s_ready,
  output logic signed [DATA_W-1:0] s_d,
  output logic [3:0]               s_idx,
  output logic                     s_last
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                   state_q, state_d;
  logic [3:0]               idx_q;
  logic                     drop_q;
  logic                     at_last;
  logic                     accept;
  logic signed [DATA_W-1:0] y_in      [16];
  logic signed [DATA_W-1:0] frame_buf [16];

  always_comb begin
    y_in[0]  = y0;
    y_in[1]  = y1;
    y_in[2]  = y2;
    y_in[3]  = y3;
    y_in[4]  = y4;
    y_in[5]  = y5;
    y_in[6]  = y6;
    y_in[7]  = y7;
    y_in[8]  = y8;
    y_in[9]  = y9;
    y_in[10] = y10;
    y_in[11] = y11;
    y_in[12] = y12;
    y_in[13] = y13;
    y_in[14] = y14;
    y_in[15] = y15;
  end

  assign at_last = (idx_q == 4'd15);

  always_comb begin
    state_d = state_q;
    p_ready = 1'b0;
    s_valid = 1'b0;
    case (state_q)
      IDLE: begin
        p_ready = 1'b1;
        if (p_valid) state_d = SEND;
      end
      SEND: begin
        s_valid = 1'b1;
        // Last element handshaking frees the buffer in the same cycle,
        // so a new frame can be taken without a bubble.
        if (s_ready && at_last) begin
          p_ready = 1'b1;
          if (!p_valid) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept = p_valid & p_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      drop_q  <= 1'b0;
      for (int unsigned i = 0; i < 16; i++) frame_buf[i] <= '0;
    end else begin
      state_q <= state_d;
      drop_q  <= p_valid & ~p_ready;
      if (accept) begin
        frame_buf <= y_in;
        idx_q     <= '0;
      end else if (state_q == SEND && s_ready && !at_last) begin
        idx_q <= idx_q + 4'd1;
      end
    end
  end

  assign s_d    = frame_buf[idx_q];
  assign s_idx  = idx_q;
  assign s_last = s_valid & at_last;
  assign drop   = drop_q;

endmodule

// File: tb/tb_p2s_serializer.sv
module tb_p2s_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        p_valid;
  logic [15:0] y [16];
  logic        p_ready;
  logic        drop;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_d;
  logic [3:0]  s_idx;
  logic        s_last;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  p2s_serializer #(.DATA_W(16)) dut (
    .clk(clk), .rst(rst), .p_valid(p_valid),
    .y0(y[0]),   .y1(y[1]),   .y2(y[2]),   .y3(y[3]),
    .y4(y[4]),   .y5(y[5]),   .y6(y[6]),   .y7(y[7]),
    .y8(y[8]),   .y9(y[9]),   .y10(y[10]), .y11(y[11]),
    .y12(y[12]), .y13(y[13]), .y14(y[14]), .y15(y[15]),
    .p_ready(p_ready), .drop(drop), .s_valid(s_valid), .s_ready(s_ready),
    .s_d(s_d), .s_idx(s_idx), .s_last(s_last)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // 0: 100k-800  1: k  2: -k-1  3: 7FFF/8000 alternating  4: 3k+5
  function automatic logic [15:0] pat(input int mode, input int k);
    int v;
    case (mode)
      0: v = 100 * k - 800;
      1: v = k;
      2: v = -k - 1;
      3: v = (k % 2 == 1) ? 32'h8000 : 32'h7FFF;
      default: v = 3 * k + 5;
    endcase
    return v[15:0];
  endfunction

  task automatic load(input int mode);
    for (int k = 0; k < 16; k++) y[k] = pat(mode, k);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_elem(input string tag, input int mode, input int k);
    check({tag, "_valid"}, 32'(s_valid), 32'd1);
    check({tag, "_d"},     32'(s_d), 32'(pat(mode, k)));
    check({tag, "_idx"},   32'(s_idx), 32'(k));
    check({tag, "_last"},  32'(s_last), 32'(k == 15));
  endtask

  // Strobe a frame in the current cycle and leave p_valid low afterwards.
  task automatic strobe(input int mode);
    load(mode);
    p_valid = 1'b1;
    #1 check("strobe_p_ready", 32'(p_ready), 32'd1);
    cyc();
    p_valid = 1'b0;
  endtask

  task automatic expect_frame(input string tag, input int mode);
    for (int k = 0; k < 16; k++) begin
      #1 check_elem(tag, mode, k);
      cyc();
    end
    #1;
    check({tag, "_end_valid"}, 32'(s_valid), 32'd0);
    check({tag, "_end_p_ready"}, 32'(p_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs;
    bit stalled15;

    rst = 1'b1; p_valid = 1'b0; s_ready = 1'b0;
    load(1);
    #12;
    check("rst_valid", 32'(s_valid), 32'd0);
    check("rst_d",     32'(s_d), 32'd0);
    check("rst_idx",   32'(s_idx), 32'd0);
    check("rst_last",  32'(s_last), 32'd0);
    check("rst_drop",  32'(drop), 32'd0);
    @(negedge clk) rst = 1'b0;
    cyc();
    check("post_rst_p_ready", 32'(p_ready), 32'd1);

    // Single frame, s_ready high throughout.
    s_ready = 1'b1;
    strobe(0);
    expect_frame("single", 0);

    // Backpressure: stalls on cycles 3-5 and on the first idx 15 cycle.
    #1;
    strobe(0);
    hs = 0;
    stalled15 = 0;
    for (int c = 1; c <= 30 && hs < 16; c++) begin
      s_ready = !(c >= 3 && c <= 5) && !(hs == 15 && !stalled15);
      if (hs == 15 && !s_ready) stalled15 = 1;
      #1 check_elem("bp", 0, hs);
      check("bp_p_ready", 32'(p_ready), 32'(hs == 15 && s_ready));
      if (s_ready) hs++;
      cyc();
    end
    check("bp_handshakes", 32'(hs), 32'd16);
    s_ready = 1'b1;
    #1 check("bp_end_valid", 32'(s_valid), 32'd0);

    // Back-to-back frames A then B, strobe B on A's last element.
    strobe(1);
    for (int k = 0; k < 16; k++) begin
      if (k == 15) begin
        load(2);
        p_valid = 1'b1;
      end
      #1 check_elem("b2b_a", 1, k);
      if (k == 15) check("b2b_p_ready", 32'(p_ready), 32'd1);
      cyc();
      p_valid = 1'b0;
    end
    expect_frame("b2b_b", 2);

    // Drop: frame B strobed in the fifth element cycle of frame A.
    #1;
    strobe(1);
    for (int k = 0; k < 16; k++) begin
      if (k == 4) begin
        load(2);
        p_valid = 1'b1;
      end else begin
        p_valid = 1'b0;
      end
      #1 check_elem("drop_a", 1, k);
      if (k == 4) check("drop_p_ready", 32'(p_ready), 32'd0);
      if (k == 5) check("drop_pulse", 32'(drop), 32'd1);
      if (k == 6 || k == 4) check("drop_quiet", 32'(drop), 32'd0);
      cyc();
    end
    p_valid = 1'b0;
    #1 check("drop_no_b", 32'(s_valid), 32'd0);

    // Extremes pass bit-exact.
    strobe(3);
    expect_frame("ext", 3);

    // Reset while idx 7 is presented.
    #1;
    strobe(1);
    for (int k = 0; k < 7; k++) begin
      #1 check_elem("mid", 1, k);
      cyc();
    end
    #1 check_elem("mid_pre", 1, 7);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(s_valid), 32'd0);
    check("mid_rst_d",     32'(s_d), 32'd0);
    check("mid_rst_idx",   32'(s_idx), 32'd0);
    check("mid_rst_last",  32'(s_last), 32'd0);
    @(negedge clk) rst = 1'b0;
    cyc();
    strobe(4);
    expect_frame("fresh", 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/p2s_serializer.md
# p2s_serializer

Parallel-to-serial converter for the frequency-analysis datapath. Accepts one 16-element frame of signed samples (e.g. transform bins) on a single-cycle strobe and emits the frame one element per cycle, in index order, over a valid/ready stream. It is the inverse of the serial-to-parallel collector that sits behind the FIR filter. It sits between the transform stage and the downstream serial consumer (magnitude/peak logic or output port).

## Interface
- DATA_W, 16, sample width (signed, two's complement)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- p_valid  in  1  single-cycle frame strobe; y0..y15 are valid only in this cycle
- y0 .. y15  in  DATA_W each  signed frame elements, index 0..15
- p_ready  out  1  frame can be accepted this cycle (combinational)
- drop  out  1  registered one-cycle pulse: a strobed frame was not accepted
- s_valid  out  1  serial output element valid
- s_ready  in  1  downstream accepts element when high with s_valid
- s_d  out  DATA_W  signed serial element
- s_idx  out  4  index of element on s_d (0..15)
- s_last  out  1  high with s_valid when s_idx == 15

## Operation
- Storage: 16 x DATA_W frame buffer, 4-bit read index idx, two-state FSM {IDLE, SEND}.
- IDLE: s_valid=0, p_ready=1. p_valid=1 -> latch y0..y15 into buffer, idx<=0, go SEND.
- SEND: s_valid=1, s_d=buf[idx], s_idx=idx, s_last=(idx==15).
  - s_ready=0: hold idx, s_d and state; the element stays presented.
  - s_ready=1, idx<15: idx<=idx+1.
  - s_ready=1, idx==15: frame done. If p_valid=1 in the same cycle, latch the new frame, set idx<=0 and stay in SEND. Otherwise go IDLE.
- p_ready = (state==IDLE) | (state==SEND & idx==15 & s_ready). p_ready is combinational from s_ready; no other path from inputs to outputs.
- p_valid=1 with p_ready=0: the frame is discarded and the buffer is untouched. drop=1 in the next cycle only. The serial stream in progress is unaffected.
- The index never wraps past 15 within a frame. Wrap from 15 to 0 happens only on acceptance of a new frame.
- Data passes bit-exact: no arithmetic, no sign or width change.

## Timing
- Reset (async assert, sync release): state=IDLE, idx=0, buffer=0, s_valid=0, s_d=0, s_idx=0, s_last=0, drop=0. p_ready=1 once reset is released.
- Reset mid-frame: the remaining elements are lost, and s_valid drops immediately on rst assertion.
- Latency: frame accepted at edge T -> s_valid=1 with s_d=y0 from cycle T+1.
- With s_ready held high: elements appear in cycles T+1..T+16, with s_last in cycle T+16.
- Back-to-back throughput: a new strobe in cycle T+16 is accepted. Its y0 appears in T+17, giving a gapless stream at one frame per 16 cycles.
- Strobe in cycles T+1..T+15 (s_ready=1), or whenever s_ready=0 in SEND: the frame is dropped.
- s_d, s_idx and s_last are stable while s_valid=1 and s_ready=0.

## Test plan
- Reset then single frame: y_k = 100*k - 800, s_ready=1 -> s_d = -800, -700, ..., 700 in 16 consecutive cycles, s_idx 0..15, s_last only on 700, then s_valid=0 and p_ready=1.
- Backpressure: same frame, s_ready low on cycles 3-5 and on the idx 15 cycle -> no element lost or repeated, and s_d holds during stalls. Exactly 16 handshakes occur.
- Back-to-back: frame A (y_k=k) strobed at T, frame B (y_k=-k-1) strobed at T+16 -> 32 gapless elements 0..15, -1..-16, with s_last at T+16 and T+32.
- Drop: strobe frame B at T+5 during frame A -> drop=1 at T+6 only, frame A completes unchanged, and frame B never appears.
- Extremes: frame of alternating 0x7FFF/0x8000 -> output matches bit-exact, including sign.
- Reset mid-frame: assert rst at idx 7 -> outputs go to reset values at once. After release, a fresh frame is serialised from idx 0.
